// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: owns the PC, issues one imem request at a time,
// hands instructions to decode and applies execute redirects. Optional FETCH_SEQ_PERF_EN adds perf counters.
module fetch_seq #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        trap,
    output logic [31:0] trap_pc,
    output logic [31:0] pc
`ifdef FETCH_SEQ_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    typedef enum logic [1:0] {BOOT, REQ, HOLD, KILL} state_t;

    state_t      state;
    logic        misaligned;
    logic [31:0] redir_pc;

    assign misaligned = (redirect_target[1:0] != 2'b00);
    assign redir_pc   = misaligned ? TRAP_VEC : redirect_target;

    assign imem_req   = (state == REQ);
    assign inst_valid = (state == HOLD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= BOOT;
            pc        <= RESET_VEC;
            imem_addr <= RESET_VEC;
            inst      <= '0;
            inst_pc   <= '0;
            trap      <= 1'b0;
            trap_pc   <= '0;
        end else begin
            trap <= redirect_valid && misaligned;
            if (redirect_valid) begin
                pc <= redir_pc;
                if (misaligned) trap_pc <= redirect_target;
                // An unacked request must drain in KILL; its address stays on imem_addr.
                case (state)
                    REQ: begin
                        if (imem_ack) imem_addr <= redir_pc;
                        else          state     <= KILL;
                    end
                    KILL: begin
                        if (imem_ack) begin
                            state     <= REQ;
                            imem_addr <= redir_pc;
                        end
                    end
                    default: begin
                        state     <= REQ;
                        imem_addr <= redir_pc;
                    end
                endcase
            end else begin
                case (state)
                    BOOT: begin
                        state     <= REQ;
                        imem_addr <= pc;
                    end
                    REQ: begin
                        if (imem_ack) begin
                            inst    <= imem_rdata;
                            inst_pc <= pc;
                            pc      <= pc + 32'd4;
                            state   <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (inst_ready) begin
                            state     <= REQ;
                            imem_addr <= pc;
                        end
                    end
                    KILL: begin
                        if (imem_ack) begin
                            state     <= REQ;
                            imem_addr <= pc;
                        end
                    end
                    default: state <= BOOT;
                endcase
            end
        end
    end

`ifdef FETCH_SEQ_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (inst_valid && inst_ready && !redirect_valid)
                perf_fetched <= perf_fetched + 32'd1;
            if ((state == REQ || state == KILL) && !imem_ack)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_seq.sv
// Randomized bench for fetch_seq: a memory responder with random ack latency, random
// decode backpressure and redirects, checked against a transaction-level reference model.
module tb_fetch_seq;

    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap;
    logic [31:0] trap_pc;
    logic [31:0] pc;
`ifdef FETCH_SEQ_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    always #5 clk = ~clk;

    fetch_seq #(.RESET_VEC(RESET_VEC), .TRAP_VEC(TRAP_VEC)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .trap(trap), .trap_pc(trap_pc), .pc(pc)
`ifdef FETCH_SEQ_PERF_EN
        , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Reference model: which phase the fetch is in, the next address to fetch, the held instruction.
    bit          m_boot, m_holding, m_abandoned, m_trap;
    logic [31:0] m_pc, m_held_pc, m_kill_addr, m_trap_pc;
    int unsigned m_fetched, m_stall, accepted_total;

    // Memory responder state.
    bit          mem_busy;
    int unsigned mem_lat;
    logic [31:0] mem_addr;

    task automatic model_reset();
        m_boot      = 1'b1;
        m_holding   = 1'b0;
        m_abandoned = 1'b0;
        m_trap      = 1'b0;
        m_pc        = RESET_VEC;
        m_held_pc   = '0;
        m_kill_addr = '0;
        m_trap_pc   = '0;
        m_fetched   = 0;
        m_stall     = 0;
        mem_busy    = 1'b0;
    endtask

    task automatic reset_check();
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_trap", 32'(trap), 32'd0);
        check("rst_trap_pc", trap_pc, 32'd0);
        check("rst_pc", pc, RESET_VEC);
    endtask

    task automatic check_outputs();
        bit exp_req;
        exp_req = !m_boot && !m_holding && !m_abandoned;
        check("imem_req", 32'(imem_req), 32'(exp_req));
        check("inst_valid", 32'(inst_valid), 32'(m_holding));
        check("pc", pc, m_pc);
        check("trap", 32'(trap), 32'(m_trap));
        check("trap_pc", trap_pc, m_trap_pc);
        if (exp_req) check("imem_addr", imem_addr, m_pc);
        if (m_abandoned) check("kill_addr", imem_addr, m_kill_addr);
        if (m_holding) begin
            check("inst_pc", inst_pc, m_held_pc);
            check("inst", inst, mem_word(m_held_pc));
        end
`ifdef FETCH_SEQ_PERF_EN
        check("perf_fetched", perf_fetched, m_fetched);
        check("perf_stall", perf_stall, m_stall);
`endif
    endtask

    task automatic drive_inputs();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        if (!mem_busy && imem_req) begin
            mem_busy = 1'b1;
            mem_addr = imem_addr;
            mem_lat  = $urandom_range(0, 3);
        end
        if (mem_busy) begin
            if (mem_lat == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(mem_addr);
                mem_busy   = 1'b0;
            end else begin
                mem_lat--;
            end
        end
        inst_ready     = 1'($urandom_range(0, 1));
        redirect_valid = ($urandom_range(0, 9) == 0);
        case ($urandom_range(0, 5))
            0: redirect_target = 32'h0000_0200;
            1: redirect_target = 32'h0000_0300;
            2: redirect_target = 32'h0000_0202;
            3: redirect_target = 32'hFFFF_FFFC;
            4: redirect_target = $urandom & 32'hFFFF_FFFC;
            default: redirect_target = $urandom;
        endcase
    endtask

    // Advance the model by one clock using the inputs just driven.
    task automatic model_step();
        if (!m_boot) begin
            if (m_holding) begin
                if (redirect_valid) m_holding = 1'b0;
                else if (inst_ready) begin
                    m_holding = 1'b0;
                    m_fetched++;
                    accepted_total++;
                end
            end else if (m_abandoned) begin
                if (imem_ack) m_abandoned = 1'b0;
                else m_stall++;
            end else begin
                if (!imem_ack) m_stall++;
                if (imem_ack && !redirect_valid) begin
                    m_holding = 1'b1;
                    m_held_pc = m_pc;
                    m_pc      = m_pc + 32'd4;
                end else if (!imem_ack && redirect_valid) begin
                    m_abandoned = 1'b1;
                    m_kill_addr = m_pc;
                end
            end
        end
        m_boot = 1'b0;
        m_trap = 1'b0;
        if (redirect_valid) begin
            if (redirect_target[1:0] != 2'b00) begin
                m_pc      = TRAP_VEC;
                m_trap    = 1'b1;
                m_trap_pc = redirect_target;
            end else begin
                m_pc = redirect_target;
            end
        end
    endtask

    task automatic run(input int unsigned cycles);
        for (int unsigned i = 0; i < cycles; i++) begin
            @(negedge clk);
            check_outputs();
            drive_inputs();
            model_step();
        end
    endtask

    // Release reset with a stale ack arriving during the boot cycle; it must be ignored.
    task automatic release_reset();
        @(negedge clk);
        reset_n        = 1'b1;
        imem_ack       = 1'b1;
        imem_rdata     = 32'hDEAD_BEEF;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        check_outputs();
        model_step();
    endtask

    initial begin
        int unsigned guard;
        reset_n         = 1'b0;
        imem_ack        = 1'b0;
        imem_rdata      = '0;
        inst_ready      = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        accepted_total  = 0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_check();
        release_reset();
        run(3000);

        // Assert reset asynchronously while a request is outstanding.
        guard = 0;
        while (guard < 50) begin
            @(negedge clk);
            check_outputs();
            if (imem_req) break;
            drive_inputs();
            model_step();
            guard++;
        end
        check("found_req", 32'(imem_req), 32'd1);
        #1;
        reset_n        = 1'b0;
        imem_ack       = 1'b0;
        redirect_valid = 1'b0;
        model_reset();
        #1;
        reset_check();
        @(negedge clk);
        reset_check();
        release_reset();
        run(2000);

        check("progress", 32'(accepted_total > 200), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
Instruction-fetch sequencer for the RISC-V core. It owns the program counter and issues one instruction-memory request at a time using a req/ack handshake. It presents each fetched instruction to decode with a valid/ready handshake. It also applies branch/jump redirects from execute and traps misaligned redirect targets to a fixed vector.

Parameters:
RESET_VEC, 32'h0000_0000, first fetch address after reset
TRAP_VEC, 32'h0000_0100, fetch address after a misaligned redirect

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous, active-low reset
imem_req  output  1  request valid to instruction memory
imem_addr  output  32  request address; stable while imem_req=1
imem_ack  input  1  one-cycle pulse, imem_rdata valid; only meaningful while a request is outstanding
imem_rdata  input  32  instruction word
inst_valid  output  1  instruction available to decode
inst  output  32  instruction word
inst_pc  output  32  address of inst
inst_ready  input  1  decode accepts inst this cycle
redirect_valid  input  1  one-cycle redirect request from execute
redirect_target  input  32  redirect address
trap  output  1  one-cycle pulse: redirect target misaligned
trap_pc  output  32  offending target, held until next trap
pc  output  32  address currently being or next to be fetched

Behaviour:
- Reset (reset_n=0, any time, asynchronous):
  - state=BOOT, pc=RESET_VEC.
  - imem_req=0, inst_valid=0, inst=0, inst_pc=0, trap=0, trap_pc=0.
  - Any outstanding request is forgotten; an imem_ack after reset release while in BOOT is ignored.
- States: BOOT, REQ, HOLD, KILL.
- BOOT: lasts exactly one cycle after reset release, then REQ.
- REQ:
  - imem_req=1, imem_addr=pc.
  - On imem_ack, latch inst=imem_rdata and inst_pc=pc, set pc=pc+4 (32-bit wrap, 0xFFFF_FFFC+4=0), go to HOLD.
  - Latency is one cycle minimum: an ack in the cycle req rises yields inst_valid the next cycle.
- HOLD:
  - inst_valid=1, imem_req=0.
  - If inst_ready=1, go to REQ next cycle; inst_valid drops.
  - inst/inst_pc stay stable while inst_valid=1 and inst_ready=0.
- Redirect: redirect_valid has priority over all normal transitions.
  - Aligned target (target[1:0]==0): pc<=target.
  - Misaligned target: pc<=TRAP_VEC, trap=1 for one cycle, trap_pc<=target.
  - In HOLD: inst_valid drops next cycle (the held instruction is squashed even if inst_ready=1 the same cycle), go to REQ.
  - In REQ without ack the same cycle: go to KILL.
  - In REQ with ack the same cycle: the returned data is discarded and the FSM goes to REQ at the new pc.
  - In KILL: pc is updated again; the last redirect wins.
  - In BOOT: pc is updated and the FSM goes to REQ.
- KILL:
  - imem_req=0; wait for the ack of the abandoned request, discard its data, then REQ.
  - imem_addr holds the old address while in KILL.
- Only one outstanding request ever exists; imem_req is never asserted in HOLD, KILL or BOOT.
- Every output comes from a register except inst_valid and imem_req, which are decoded from state only.

Optional Feature:
FETCH_SEQ_PERF_EN.
- Defined:
  - Adds outputs perf_fetched[31:0] (increments on each instruction accepted by decode: inst_valid&inst_ready&!redirect_valid).
  - Adds perf_stall[31:0] (increments each cycle in REQ or KILL without imem_ack).
  - Both are asynchronously reset to 0 and wrap at 2^32.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, imem_ack returned one cycle after every req, inst_ready=1 -> fetch addresses 0x0, 0x4, 0x8 in order; each inst_valid has the matching inst_pc; trap stays 0.
- Hold inst_ready=0 for 5 cycles with inst at pc 0x8 -> inst/inst_pc constant and imem_req=0 throughout; the next request is 0xC after inst_ready rises.
- redirect_valid with target 0x200 while in HOLD with inst_ready=1 -> the held instruction is not counted as accepted; the next imem_addr is 0x200.
- redirect_valid with target 0x300 during an outstanding REQ, ack arriving 3 cycles later with 0xDEADBEEF -> the data is never presented on inst; the next request is to 0x300.
- redirect_valid with target 0x202 -> trap=1 for one cycle, trap_pc=0x202, next fetch at 0x100.
- Drive reset_n low mid-request, then release it and deliver a stale imem_ack while in BOOT -> ack ignored; the first post-reset request is to RESET_VEC.
